fft_iter: RTL and testbench

FFT_ITER -- requirements
Module: fft_iter

---
 rtl/fft_iter.sv | 190 +++++++++++++++++++
 tb/tb_fft_iter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_iter.sv
// fft_iter: iterative N-point radix-2 decimation-in-time FFT.
// Samples are streamed in, stored at bit-reversed addresses, transformed
// in place at one butterfly per clock, then streamed out in natural order.
// Optional build macro: FFT_SCALE_EN halves both butterfly outputs at every
// stage, giving an overall 1/N scaling.
module fft_iter #(
    parameter int W    = 16,
    parameter int LOGN = 3,
    parameter int FRAC = 11
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*W-1:0]    in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_data,
    output logic              out_last,
    output logic [LOGN-2:0]   tw_addr,
    input  logic [2*W-1:0]    tw_data,
    output logic              busy
);
    localparam int N  = 1 << LOGN;
    localparam int SW = $clog2(LOGN);
    // Only the low W+FRAC bits of a product survive the shift-and-truncate,
    // so the products are formed modulo 2^(W+FRAC).
    localparam int PW = W + FRAC;

    localparam logic [LOGN-1:0] CNT_LAST = LOGN'(N - 1);
    localparam logic [LOGN-2:0] BF_LAST  = '1;
    localparam logic [SW-1:0]   ST_LAST  = SW'(LOGN - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_UNLOAD} state_t;

    state_t              r_state;
    logic [LOGN-1:0]     r_cnt;
    logic [LOGN-2:0]     r_bf;
    logic [SW-1:0]       r_stage;
    logic [LOGN-1:0]     r_ucnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_out_last;
    logic [2*W-1:0]      r_out_data;
    logic                r_busy;
    logic [2*W-1:0]      r_mem [N];

    logic [LOGN-1:0]     w_ld_addr;
    logic                w_ld_we;
    logic [LOGN-1:0]     w_bfx, w_mask, w_j, w_top, w_bot, w_kfull;
    logic [SW-1:0]       w_ksh;
    logic [2*W-1:0]      w_a, w_b, w_top_new, w_bot_new;
    logic signed [W-1:0] w_ar, w_ai, w_br, w_bi, w_wr, w_wi, w_tr, w_ti;
    logic signed [PW-1:0] w_pr, w_pi;
    logic [W:0]          w_sr, w_si, w_dr, w_di;
    logic                w_unused;

    // Load address is the bit-reversed sample count.
    genvar gi;
    generate
        for (gi = 0; gi < LOGN; gi++) begin : g_rev
            assign w_ld_addr[gi] = r_cnt[LOGN-1-gi];
        end
    endgenerate

    assign w_ld_we   = in_valid && in_ready;
    assign in_ready  = r_in_ready && !rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign tw_addr   = (r_state == S_CALC) ? w_kfull[LOGN-2:0] : '0;

    // Butterfly addressing: top = g*2h + j, bottom = top + h, k = j*N/(2h).
    always_comb begin
        w_bfx   = {1'b0, r_bf};
        w_mask  = (LOGN'(1) << r_stage) - LOGN'(1);
        w_j     = w_bfx & w_mask;
        w_top   = (((w_bfx >> r_stage) << r_stage) << 1) | w_j;
        w_bot   = w_top | (LOGN'(1) << r_stage);
        w_ksh   = ST_LAST - r_stage;
        w_kfull = w_j << w_ksh;
    end

    // Complex multiply t = W_k * b, then a +/- t with wrap-around.
    always_comb begin
        w_a  = r_mem[w_top];
        w_b  = r_mem[w_bot];
        w_ar = w_a[2*W-1:W];
        w_ai = w_a[W-1:0];
        w_br = w_b[2*W-1:W];
        w_bi = w_b[W-1:0];
        w_wr = tw_data[2*W-1:W];
        w_wi = tw_data[W-1:0];
        w_pr = PW'(w_wr) * PW'(w_br) - PW'(w_wi) * PW'(w_bi);
        w_pi = PW'(w_wr) * PW'(w_bi) + PW'(w_wi) * PW'(w_br);
        w_tr = w_pr[PW-1:FRAC];
        w_ti = w_pi[PW-1:FRAC];
        w_sr = {w_ar[W-1], w_ar} + {w_tr[W-1], w_tr};
        w_si = {w_ai[W-1], w_ai} + {w_ti[W-1], w_ti};
        w_dr = {w_ar[W-1], w_ar} - {w_tr[W-1], w_tr};
        w_di = {w_ai[W-1], w_ai} - {w_ti[W-1], w_ti};
`ifdef FFT_SCALE_EN
        w_top_new = {w_sr[W:1], w_si[W:1]};
        w_bot_new = {w_dr[W:1], w_di[W:1]};
        w_unused  = ^{w_pr[FRAC-1:0], w_pi[FRAC-1:0], w_kfull[LOGN-1],
                      w_sr[0], w_si[0], w_dr[0], w_di[0]};
`else
        w_top_new = {w_sr[W-1:0], w_si[W-1:0]};
        w_bot_new = {w_dr[W-1:0], w_di[W-1:0]};
        w_unused  = ^{w_pr[FRAC-1:0], w_pi[FRAC-1:0], w_kfull[LOGN-1],
                      w_sr[W], w_si[W], w_dr[W], w_di[W]};
`endif
    end

    // Sample buffer: one load write port, two butterfly write ports; never reset.
    always_ff @(posedge ck) begin
        if (w_ld_we) begin
            r_mem[w_ld_addr] <= in_data;
        end
        if (r_state == S_CALC) begin
            r_mem[w_top] <= w_top_new;
            r_mem[w_bot] <= w_bot_new;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bf        <= '0;
            r_stage     <= '0;
            r_ucnt      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_ld_we) begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_busy <= 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state    <= S_CALC;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_CALC: begin
                    r_bf <= r_bf + 1'b1;
                    if (r_bf == BF_LAST) begin
                        r_stage <= r_stage + 1'b1;
                        if (r_stage == ST_LAST) begin
                            // Bin 0 was finalised by the first butterfly of
                            // the last stage, so it can be presented now.
                            r_stage     <= '0;
                            r_state     <= S_UNLOAD;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_out_data  <= r_mem[0];
                            r_ucnt      <= LOGN'(1);
                        end
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_ucnt      <= '0;
                        end else begin
                            r_out_data <= r_mem[r_ucnt];
                            r_out_last <= (r_ucnt == CNT_LAST);
                            r_ucnt     <= r_ucnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_iter.sv
// tb_fft_iter: directed bench for fft_iter (W=16, LOGN=3, FRAC=11) with a
// scoreboard queue of expected bins and a bit-exact reference FFT.
module tb_fft_iter;
    localparam int W    = 16;
    localparam int LOGN = 3;
    localparam int FRAC = 11;
    localparam int N    = 8;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic [1:0]  tw_addr;
    logic [31:0] tw_data;
    logic        busy;

    logic [31:0] tw_rom [4] = '{32'h0800_0000, 32'h05A8_FA58, 32'h0000_F800, 32'hFA58_FA58};
    assign tw_data = tw_rom[tw_addr];

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] sb [$];
    logic [31:0] frame_in [N];
    logic [31:0] rx [N];

    fft_iter #(.W(W), .LOGN(LOGN), .FRAC(FRAC)) dut (
        .ck(ck), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .tw_addr(tw_addr), .tw_data(tw_data), .busy(busy)
    );

    always #5 ck = ~ck;

    initial begin
        #400000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        n_vec++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    function automatic int bitrev(input int n);
        int r = 0;
        for (int i = 0; i < LOGN; i++)
            if (n[i]) r |= 1 << (LOGN - 1 - i);
        return r;
    endfunction

    // Reference DIT FFT on frame_in; pushes expected {last, bin} entries.
    task automatic model_push();
        logic [31:0] m [N];
        longint ar, ai, br, bi, wr, wi, pr, pi;
        int tr, ti, sr, si, dr, di, top, bot, k, h;
        logic [31:0] wv;
        for (int n = 0; n < N; n++) m[bitrev(n)] = frame_in[n];
        for (int s = 0; s < LOGN; s++) begin
            h = 1 << s;
            for (int g = 0; g < N / (2 * h); g++) begin
                for (int j = 0; j < h; j++) begin
                    top = g * 2 * h + j;
                    bot = top + h;
                    k   = j * N / (2 * h);
                    wv  = tw_rom[k];
                    ar = $signed(m[top][31:16]); ai = $signed(m[top][15:0]);
                    br = $signed(m[bot][31:16]); bi = $signed(m[bot][15:0]);
                    wr = $signed(wv[31:16]);     wi = $signed(wv[15:0]);
                    pr = (wr * br - wi * bi) >>> FRAC;
                    pi = (wr * bi + wi * br) >>> FRAC;
                    tr = $signed(pr[15:0]);
                    ti = $signed(pi[15:0]);
                    sr = int'(ar) + tr; si = int'(ai) + ti;
                    dr = int'(ar) - tr; di = int'(ai) - ti;
`ifdef FFT_SCALE_EN
                    sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
`endif
                    m[top] = {sr[15:0], si[15:0]};
                    m[bot] = {dr[15:0], di[15:0]};
                end
            end
        end
        for (int b = 0; b < N; b++) sb.push_back({(b == N - 1), m[b]});
    endtask

    task automatic push_const(input logic [31:0] bin0, input logic [31:0] rest);
        for (int b = 0; b < N; b++) sb.push_back({(b == N - 1), (b == 0) ? bin0 : rest});
    endtask

    // Streams frame_in into the DUT; gap>0 inserts idle cycles before some samples.
    task automatic drive_frame(input int gap);
        logic acc;
        int t;
        for (int n = 0; n < N; n++) begin
            if (gap > 0 && (n % 3) == 1) begin
                in_valid = 1'b0;
                repeat (gap) step();
            end
            in_valid = 1'b1;
            in_data  = frame_in[n];
            t = 0;
            do begin
                acc = in_ready;
                step();
                t++;
            end while (!acc && t < 50);
            if (!acc) check("load_timeout", {63'b0, acc}, 64'd1);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Collects N bins, comparing against the scoreboard; stalls 5 cycles at bin stall_at.
    task automatic recv_frame(input int stall_at);
        logic [32:0] e;
        logic [31:0] hold_d;
        logic        hold_l;
        int t;
        out_ready = 1'b1;
        for (int b = 0; b < N; b++) begin
            t = 0;
            while (!out_valid && t < 200) begin
                step();
                t++;
            end
            if (!out_valid) begin
                check("recv_timeout", {63'b0, out_valid}, 64'd1);
                return;
            end
            if (b == stall_at) begin
                out_ready = 1'b0;
                hold_d = out_data;
                hold_l = out_last;
                repeat (5) begin
                    step();
                    check("stall_data", out_data, hold_d);
                    check("stall_last", out_last, hold_l);
                    check("stall_valid", out_valid, 1);
                end
                out_ready = 1'b1;
            end
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
                return;
            end
            e = sb.pop_front();
            check($sformatf("bin%0d_data", b), out_data, e[31:0]);
            check($sformatf("bin%0d_last", b), out_last, e[32]);
            rx[b] = out_data;
            step();
        end
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        logic [31:0] imp_exp, dc0_exp;
        int kexp [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        int cnt;
`ifdef FFT_SCALE_EN
        imp_exp = 32'h0100_0000;
        dc0_exp = 32'h0800_0000;
`else
        imp_exp = 32'h0800_0000;
        dc0_exp = 32'h4000_0000;
`endif
        // Reset state.
        rst = 1'b1;
        repeat (2) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_tw_addr", tw_addr, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // Impulse.
        for (int n = 0; n < N; n++) frame_in[n] = (n == 0) ? 32'h0800_0000 : 32'h0;
        drive_frame(0);
        push_const(imp_exp, imp_exp);
        recv_frame(-1);

        // DC with CALC length and twiddle sequence.
        for (int n = 0; n < N; n++) frame_in[n] = 32'h0800_0000;
        drive_frame(0);
        push_const(dc0_exp, 32'h0);
        check("calc_busy", busy, 1);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            if (cnt < 12) check($sformatf("tw_addr_%0d", cnt), tw_addr, kexp[cnt]);
            cnt++;
            step();
        end
        check("calc_cycles", cnt, 12);
        recv_frame(-1);

        // Single tone at bin 2 with output backpressure.
        for (int n = 0; n < N; n++) frame_in[n] = 32'h0;
        frame_in[1] = 32'h07FF_0000; frame_in[5] = 32'h07FF_0000;
        frame_in[3] = 32'hF801_0000; frame_in[7] = 32'hF801_0000;
        drive_frame(0);
        model_push();
        recv_frame(3);
`ifndef FFT_SCALE_EN
        for (int b = 0; b < N; b++) begin
            check_near($sformatf("tone_re%0d", b), $signed(rx[b][31:16]), 0, 2);
            check_near($sformatf("tone_im%0d", b), $signed(rx[b][15:0]),
                       (b == 2) ? -8188 : (b == 6) ? 8188 : 0, 2);
        end
`endif

        // Reset in the middle of CALC, then a clean impulse frame.
        for (int n = 0; n < N; n++) frame_in[n] = (n == 0) ? 32'h0800_0000 : 32'h0;
        drive_frame(0);
        repeat (4) step();
        check("midcalc_busy", busy, 1);
        rst = 1'b1;
        step();
        check("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("after_rst_busy", busy, 0);
        check("after_rst_out_valid", out_valid, 0);
        check("after_rst_in_ready", in_ready, 1);
        drive_frame(0);
        push_const(imp_exp, imp_exp);
        recv_frame(-1);

        // Two random frames back to back with input gaps.
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < N; n++) frame_in[n] = $urandom;
            drive_frame(f + 1);
            model_push();
            recv_frame(f == 0 ? 6 : -1);
        end

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
